// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared constants and helpers for the multi-port register file slice.
// Holds the default geometry (data width, depth, read-port count) and the
// address-width derivation used by regfile_mp and regfile_mp_rdport.
// Build option: REGFILE_MP_BYPASS_EN (consumed by the other files).
package regfile_mp_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_N_RD   = 2;

  // Address width for a register file of the given depth; never below one
  // bit so that degenerate depths still produce a legal vector.
  function automatic int addrWidth(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport
// One registered read port of regfile_mp. On a clock edge with rdEnable set
// it captures the selected register (or the forwarded write data when the
// bypass is compiled in) together with that register's busy flag; otherwise
// it holds its previous outputs.
// Build option: REGFILE_MP_BYPASS_EN adds the write-to-read forwarding mux.
// Ports:
//   clock, reset             clock and asynchronous active-high reset
//   rdEnable                 read strobe for this port
//   fileData                 storage contents at this port's address
//   busyIn                   scoreboard bit after this edge's updates
//   bypassHit, bypassData    forwarding select and data (bypass builds only)
//   rdData, rdBusy           registered read results
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rdEnable,
  input  logic [DATA_W-1:0] fileData,
  input  logic              busyIn,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic              bypassHit,
  input  logic [DATA_W-1:0] bypassData,
`endif
  output logic [DATA_W-1:0] rdData,
  output logic              rdBusy
);

  logic [DATA_W-1:0] selData;

  // Pick the value this port would capture: forwarded write data when the
  // write in flight targets the same register, otherwise stored contents.
`ifdef REGFILE_MP_BYPASS_EN
  always_comb begin
    selData = bypassHit ? bypassData : fileData;
  end
`else
  always_comb begin
    selData = fileData;
  end
`endif

  // Output registers only load on a strobed read so an idle port keeps
  // presenting its last result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdData <= '0;
      rdBusy <= 1'b0;
    end else if (rdEnable) begin
      rdData <= selData;
      rdBusy <= busyIn;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file with a write-pending scoreboard. One write port,
// N_RD registered read ports, and a reserve port that marks a register busy
// until it is written. Register 0 can be hardwired to zero (ZERO_REG).
// Build option: REGFILE_MP_BYPASS_EN enables write-first forwarding.
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   rdEnable[N_RD]       per-port read strobes
//   rdAddr               packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdData               packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rdBusy[N_RD]         registered busy flag of the register read on port k
//   wrEnable/wrAddr/wrData   write port (a write also clears the busy bit)
//   rsvEnable/rsvAddr    reserve port (sets the busy bit)
//   anyBusy              OR of every scoreboard bit
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int N_RD     = DEFAULT_N_RD,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = addrWidth(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_RD-1:0]          rdEnable,
  input  logic [N_RD*ADDR_W-1:0]   rdAddr,
  output logic [N_RD*DATA_W-1:0]   rdData,
  output logic [N_RD-1:0]          rdBusy,
  input  logic                     wrEnable,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     rsvEnable,
  input  logic [ADDR_W-1:0]        rsvAddr,
  output logic                     anyBusy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic              wrOk;
  logic              rsvOk;

  // Accesses aimed at a hardwired-zero register 0 are dropped here so that
  // neither storage nor scoreboard ever records them.
  always_comb begin
    wrOk  = wrEnable  && !(ZR && (wrAddr  == '0));
    rsvOk = rsvEnable && !(ZR && (rsvAddr == '0));
  end

  // Scoreboard after this edge: the write clears its bit first, then the
  // reserve sets its bit, so a reserve to the same register wins.
  always_comb begin
    busyNext = busy;
    if (wrOk) begin
      busyNext[wrAddr] = 1'b0;
    end
    if (rsvOk) begin
      busyNext[rsvAddr] = 1'b1;
    end
  end

  // Storage array; every register clears on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wrOk) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign anyBusy = |busy;

  // One registered port per reader. The port sees the post-update busy bit
  // so a read in the same cycle as a reserve or write reports the new state.
  for (genvar k = 0; k < N_RD; k++) begin : gRd
    logic [ADDR_W-1:0] addr;
    logic              isZero;
    logic [DATA_W-1:0] fileData;
    logic              busyIn;

    assign addr     = rdAddr[k*ADDR_W +: ADDR_W];
    assign isZero   = ZR && (addr == '0);
    assign fileData = isZero ? '0 : mem[addr];
    assign busyIn   = isZero ? 1'b0 : busyNext[addr];

`ifdef REGFILE_MP_BYPASS_EN
    logic bypassHit;
    assign bypassHit = wrOk && (wrAddr == addr);
`endif

    regfile_mp_rdport #(
      .DATA_W (DATA_W)
    ) uRdPort (
      .clock      (clock),
      .reset      (reset),
      .rdEnable   (rdEnable[k]),
      .fileData   (fileData),
      .busyIn     (busyIn),
`ifdef REGFILE_MP_BYPASS_EN
      .bypassHit  (bypassHit),
      .bypassData (wrData),
`endif
      .rdData     (rdData[k*DATA_W +: DATA_W]),
      .rdBusy     (rdBusy[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, data word width in bits (8..64).
REQ-002 Parameter DEPTH, 32, number of registers (power of two, 4..64); ADDR_W = clog2(DEPTH).
REQ-003 Parameter N_RD, 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes/reservations.
REQ-005 clock  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 rdEnable  input  N_RD  per-port read strobe.
REQ-008 rdAddr  input  N_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 rdData  output  N_RD*DATA_W  packed registered read data, port k at [k*DATA_W +: DATA_W].
REQ-010 rdBusy  output  N_RD  registered pending-write flag of the register read on port k.
REQ-011 wrEnable  input  1  write strobe.
REQ-012 wrAddr  input  ADDR_W  write address.
REQ-013 wrData  input  DATA_W  write data.
REQ-014 rsvEnable  input  1  scoreboard reserve strobe (a write to rsvAddr is outstanding).
REQ-015 rsvAddr  input  ADDR_W  register to mark busy.
REQ-016 anyBusy  output  1  combinational OR of all scoreboard bits.

Function
REQ-017 Read latency SHALL be exactly one cycle: rdData[k] and rdBusy[k] update on the edge where rdEnable[k]=1 was sampled.
REQ-018 With rdEnable[k]=0, rdData[k] and rdBusy[k] SHALL hold their previous values.
REQ-019 A write with wrEnable=1 SHALL update file[wrAddr] on the sampling edge; no write when wrEnable=0.
REQ-020 Same-cycle read and write of the same address: rdData SHALL return wrData (write-first) when bypass is compiled in, old contents otherwise (see REQ-031).
REQ-021 Multiple read ports addressing the same register SHALL return identical data.
REQ-022 rsvEnable=1 SHALL set busy[rsvAddr]; wrEnable=1 SHALL clear busy[wrAddr].
REQ-023 Simultaneous reserve and write to the same address: reserve SHALL win (bit ends set); different addresses: both take effect.
REQ-024 rdBusy[k] SHALL reflect the scoreboard state after the same-edge updates of REQ-022/023.
REQ-025 ZERO_REG=1: reads of address 0 SHALL return 0 and rdBusy 0; writes and reserves to address 0 SHALL be discarded.
REQ-026 Writing a non-busy register SHALL be legal and SHALL leave its busy bit clear.

Reset
REQ-027 While reset=1, all registers, rdData, rdBusy and every scoreboard bit SHALL be 0 immediately, independent of clock.
REQ-028 Reset deasserted mid-operation: strobes on the first rising edge after deassertion SHALL be honoured normally; strobes during reset SHALL be lost.
REQ-029 anyBusy SHALL be 0 during and directly after reset.

Configuration
REQ-030 Macro REGFILE_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 Defined: same-address same-cycle read returns wrData and rdBusy 0 (unless reserved same cycle); undefined: returns prior contents and prior-state busy is replaced only by REQ-024 rules for busy; data path has no forwarding mux.

Structure
REQ-032 Shared package regfile_mp_pkg SHALL hold default DATA_W/DEPTH/N_RD constants and the ADDR_W derivation function.
REQ-033 One sub-module regfile_mp_rdport (single registered read port with optional bypass mux) SHALL be instantiated N_RD times via generate.
REQ-034 The storage array and scoreboard SHALL reside in the top module.

Verification
REQ-035 Reset: write 0xDEADBEEF to r5, assert reset between edges -> rdData/rdBusy 0 at once; read r5 after release -> 0.
REQ-036 Write r3=0x12345678, read r3 next cycle on ports 0 and 1 -> both 0x12345678 one cycle after rdEnable.
REQ-037 Same cycle write r7=0xA5A5A5A5 and read r7 (old 0x0) -> 0xA5A5A5A5 with REGFILE_MP_BYPASS_EN, 0x0 without.
REQ-038 Reserve r9, read r9 -> rdBusy=1, anyBusy=1; write r9=0x1 -> next read rdBusy=0, anyBusy=0.
REQ-039 Same cycle reserve r4 and write r4=0x55 -> busy[4] stays 1, file[4]=0x55.
REQ-040 ZERO_REG=1: write r0=0xFFFFFFFF, reserve r0, read r0 -> rdData 0, rdBusy 0, anyBusy 0.
